// File: rtl/d_mem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// d_mem_lsu_pkg
// Shared definitions for the load/store unit:
//   - funct3 access-size codes (SZ_B/H/W/BU/HU)
//   - FSM state encoding (IDLE/XFER/DONE)
//   - byte_count(): number of byte transfers for a size code
//   - access_illegal(): start-time rejection of bad requests
// -----------------------------------------------------------------------------
package d_mem_lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // The low two funct3 bits encode width; bit 2 only selects zero-extension.
    function automatic logic [2:0] byte_count(input logic [2:0] size);
        logic [2:0] n;
        case (size[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Conflicting enables, reserved size codes, unsigned stores and
    // misaligned halfword/word accesses are rejected before touching the bus.
    function automatic logic access_illegal(input logic       rd,
                                            input logic       wr,
                                            input logic [2:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (rd && wr)
            bad = 1'b1;
        if ((size == 3'b011) || (size == 3'b110) || (size == 3'b111))
            bad = 1'b1;
        if (wr && size[2])
            bad = 1'b1;
        if ((size[1:0] == 2'b01) && addr_lo[0])
            bad = 1'b1;
        if ((size[1:0] == 2'b10) && (addr_lo != 2'b00))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/d_mem_lsu_ld_extend.sv
// -----------------------------------------------------------------------------
// ld_extend
// Combinational load-result formatter: takes the little-endian word assembled
// from the byte bus and the funct3 size, returns the sign- or zero-extended
// value written back to the register file.
// Ports:
//   word_i    assembled load word (byte 0 in the low bits)
//   size_i    funct3 size code
//   result_o  extended load result
// -----------------------------------------------------------------------------
module ld_extend
    import d_mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [2:0]            size_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int HALF_WIDTH = 2 * BYTE_WIDTH;

    always_comb begin
        result_o = word_i;
        case (size_i)
            SZ_B:  result_o = {{(DATA_WIDTH-BYTE_WIDTH){word_i[BYTE_WIDTH-1]}},
                              word_i[BYTE_WIDTH-1:0]};
            SZ_H:  result_o = {{(DATA_WIDTH-HALF_WIDTH){word_i[HALF_WIDTH-1]}},
                              word_i[HALF_WIDTH-1:0]};
            SZ_BU: result_o = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, word_i[BYTE_WIDTH-1:0]};
            SZ_HU: result_o = {{(DATA_WIDTH-HALF_WIDTH){1'b0}}, word_i[HALF_WIDTH-1:0]};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/d_mem_lsu.sv
// -----------------------------------------------------------------------------
// d_mem_lsu
// Load/store unit between the single-cycle core's data-memory controls and a
// byte-wide req/ack memory bus. Each LB/LH/LW/LBU/LHU/SB/SH/SW is split into
// 1/2/4 little-endian byte transfers; busy stalls the core until completion.
// Ports:
//   clk_t, rst_t          clock (rising edge), async active-high reset
//   d_mem_rd_en_t/wr_en_t load / store request from control
//   d_mem_size_t          funct3 size code
//   d_mem_addr_t          byte address
//   d_mem_wr_data_t       store data
//   d_mem_rd_data_t       extended load result, held until next good load
//   d_mem_busy_t          combinational stall to the core
//   d_mem_done_t          one-cycle completion pulse
//   d_mem_err_t           with done: misaligned/illegal/timeout
//   mem_req_t/we_t        byte bus request / write strobe
//   mem_addr_t/wdata_t    byte bus address / write byte
//   mem_rdata_t/ack_t     byte bus read data / acknowledge
// -----------------------------------------------------------------------------
module d_mem_lsu
    import d_mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk_t,
    input  logic                  rst_t,
    input  logic                  d_mem_rd_en_t,
    input  logic                  d_mem_wr_en_t,
    input  logic [2:0]            d_mem_size_t,
    input  logic [ADDR_WIDTH-1:0] d_mem_addr_t,
    input  logic [DATA_WIDTH-1:0] d_mem_wr_data_t,
    output logic [DATA_WIDTH-1:0] d_mem_rd_data_t,
    output logic                  d_mem_busy_t,
    output logic                  d_mem_done_t,
    output logic                  d_mem_err_t,
    output logic                  mem_req_t,
    output logic                  mem_we_t,
    output logic [ADDR_WIDTH-1:0] mem_addr_t,
    output logic [BYTE_WIDTH-1:0] mem_wdata_t,
    input  logic [BYTE_WIDTH-1:0] mem_rdata_t,
    input  logic                  mem_ack_t
);

    localparam int TMO_WIDTH = $clog2(ACK_TIMEOUT + 1);

    lsu_state_e            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] base_q,    base_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [2:0]            size_q,    size_d;
    logic                  dir_q,     dir_d;
    logic [1:0]            last_q,    last_d;
    logic [1:0]            idx_q,     idx_d;
    logic [TMO_WIDTH-1:0]  tmo_q,     tmo_d;
    logic [DATA_WIDTH-1:0] asm_q,     asm_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  err_q,     err_d;

    logic [TMO_WIDTH-1:0]  tmo_inc;
    logic [DATA_WIDTH-1:0] asm_merged;
    logic [DATA_WIDTH-1:0] ld_result;

    // The byte arriving this cycle is merged ahead of the register so the
    // final byte can be extended and written to rd_data on the same edge.
    always_comb begin
        asm_merged = asm_q;
        asm_merged[idx_q*BYTE_WIDTH +: BYTE_WIDTH] = mem_rdata_t;
    end

    ld_extend #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_ld_extend (
        .word_i   (asm_merged),
        .size_i   (size_q),
        .result_o (ld_result)
    );

    assign tmo_inc = tmo_q + TMO_WIDTH'(1);

    // Next-state and output logic. Bus outputs are zero outside XFER so a
    // reset mid-transfer drops the request as soon as the state clears.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        dir_d        = dir_q;
        last_d       = last_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        asm_d        = asm_q;
        rd_data_d    = rd_data_q;
        err_d        = err_q;
        d_mem_busy_t = 1'b0;
        d_mem_done_t = 1'b0;
        d_mem_err_t  = 1'b0;
        mem_req_t    = 1'b0;
        mem_we_t     = 1'b0;
        mem_addr_t   = '0;
        mem_wdata_t  = '0;

        case (state_q)
            ST_IDLE: begin
                if (d_mem_rd_en_t || d_mem_wr_en_t) begin
                    d_mem_busy_t = 1'b1;
                    base_d       = d_mem_addr_t;
                    wdata_d      = d_mem_wr_data_t;
                    size_d       = d_mem_size_t;
                    dir_d        = d_mem_wr_en_t;
                    last_d       = 2'(byte_count(d_mem_size_t) - 3'd1);
                    idx_d        = 2'd0;
                    tmo_d        = '0;
                    asm_d        = '0;
                    if (access_illegal(d_mem_rd_en_t, d_mem_wr_en_t,
                                       d_mem_size_t, d_mem_addr_t[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_XFER;
                    end
                end
            end

            ST_XFER: begin
                d_mem_busy_t = 1'b1;
                mem_req_t    = 1'b1;
                mem_we_t     = dir_q;
                mem_addr_t   = base_q + ADDR_WIDTH'(idx_q);
                mem_wdata_t  = wdata_q[idx_q*BYTE_WIDTH +: BYTE_WIDTH];
                if (mem_ack_t) begin
                    asm_d = asm_merged;
                    tmo_d = '0;
                    if (idx_q == last_q) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                        if (!dir_q)
                            rd_data_d = ld_result;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (tmo_inc == TMO_WIDTH'(ACK_TIMEOUT)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end

            ST_DONE: begin
                d_mem_done_t = 1'b1;
                d_mem_err_t  = err_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_t or posedge rst_t) begin
        if (rst_t) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            dir_q     <= 1'b0;
            last_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            asm_q     <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            asm_q     <= asm_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign d_mem_rd_data_t = rd_data_q;

endmodule

// File: tb/tb_d_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_d_mem_lsu
// Bench for d_mem_lsu with a behavioural byte memory that answers the bus
// after a programmable number of wait states (or never). Expected results come
// from a word-level model of the RISC-V load/store rules.
// -----------------------------------------------------------------------------
module tb_d_mem_lsu;

    logic        clk_t = 1'b0;
    logic        rst_t = 1'b1;
    logic        d_mem_rd_en_t = 1'b0;
    logic        d_mem_wr_en_t = 1'b0;
    logic [2:0]  d_mem_size_t = 3'b000;
    logic [31:0] d_mem_addr_t = 32'h0;
    logic [31:0] d_mem_wr_data_t = 32'h0;
    logic [31:0] d_mem_rd_data_t;
    logic        d_mem_busy_t;
    logic        d_mem_done_t;
    logic        d_mem_err_t;
    logic        mem_req_t;
    logic        mem_we_t;
    logic [31:0] mem_addr_t;
    logic [7:0]  mem_wdata_t;
    logic [7:0]  mem_rdata_t = 8'h00;
    logic        mem_ack_t = 1'b0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } xfer_t;

    xfer_t       xlog[$];
    logic [7:0]  mem [logic [31:0]];
    int          wait_states = 0;
    bit          never_ack = 1'b0;
    int          req_cycles = 0;
    int          wait_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rd = 32'h0;

    d_mem_lsu #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .BYTE_WIDTH  (8),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk_t           (clk_t),
        .rst_t           (rst_t),
        .d_mem_rd_en_t   (d_mem_rd_en_t),
        .d_mem_wr_en_t   (d_mem_wr_en_t),
        .d_mem_size_t    (d_mem_size_t),
        .d_mem_addr_t    (d_mem_addr_t),
        .d_mem_wr_data_t (d_mem_wr_data_t),
        .d_mem_rd_data_t (d_mem_rd_data_t),
        .d_mem_busy_t    (d_mem_busy_t),
        .d_mem_done_t    (d_mem_done_t),
        .d_mem_err_t     (d_mem_err_t),
        .mem_req_t       (mem_req_t),
        .mem_we_t        (mem_we_t),
        .mem_addr_t      (mem_addr_t),
        .mem_wdata_t     (mem_wdata_t),
        .mem_rdata_t     (mem_rdata_t),
        .mem_ack_t       (mem_ack_t)
    );

    always #5 clk_t = ~clk_t;

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic int model_nbytes(input logic [2:0] size);
        case (size)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit model_illegal(input bit rd, input bit wr,
                                         input logic [2:0] size, input logic [31:0] addr);
        int n;
        n = model_nbytes(size);
        if (rd && wr) return 1'b1;
        if (n == 0) return 1'b1;
        if (wr && (size >= 3'd4)) return 1'b1;
        if ((addr % n) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr);
        logic [31:0] w;
        byte         sb;
        shortint     sh;
        w = 32'h0;
        for (int k = 0; k < model_nbytes(size); k++)
            w = w | (32'(rd_mem(addr + 32'(k))) << (8 * k));
        sb = w[7:0];
        sh = w[15:0];
        case (size)
            3'b000:  return 32'(int'(sb));
            3'b001:  return 32'(int'(sh));
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Memory responder: acks after wait_states cycles of request, logs every
    // accepted transfer. Store effects are applied by the driver afterwards.
    always @(negedge clk_t) begin
        if (rst_t) begin
            mem_ack_t = 1'b0;
            wait_cnt  = 0;
        end else if (mem_req_t) begin
            req_cycles++;
            if (!never_ack && (wait_cnt >= wait_states)) begin
                mem_ack_t   = 1'b1;
                mem_rdata_t = rd_mem(mem_addr_t);
                xlog.push_back(xfer_t'{mem_we_t, mem_addr_t, mem_we_t ? mem_wdata_t : 8'h00});
                wait_cnt    = 0;
            end else begin
                mem_ack_t = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack_t   = 1'b0;
            mem_rdata_t = 8'h00;
            wait_cnt    = 0;
        end
    end

    // Drives one core request, holding it until the done pulse like a
    // stalled core, and reports what was observed.
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int busy_cycles, output bit saw_done,
                             output bit err_out, output int log_base, output int n_req);
        int req_base;
        log_base = xlog.size();
        req_base = req_cycles;
        saw_done = 1'b0;
        err_out  = 1'b0;
        @(negedge clk_t);
        d_mem_rd_en_t   = rd;
        d_mem_wr_en_t   = wr;
        d_mem_size_t    = size;
        d_mem_addr_t    = addr;
        d_mem_wr_data_t = data;
        #1;
        busy_cycles = d_mem_busy_t ? 1 : 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_t);
            #1;
            if (d_mem_done_t) begin
                saw_done = 1'b1;
                err_out  = d_mem_err_t;
                break;
            end
            if (d_mem_busy_t) busy_cycles++;
        end
        d_mem_rd_en_t = 1'b0;
        d_mem_wr_en_t = 1'b0;
        n_req = req_cycles - req_base;
        for (int i = log_base; i < xlog.size(); i++)
            if (xlog[i].we) mem[xlog[i].addr] = xlog[i].data;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_t);
        #1;
        n_checks++; if (d_mem_busy_t !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", d_mem_busy_t); end
        n_checks++; if (d_mem_done_t !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got=%b exp=0", d_mem_done_t); end
        n_checks++; if (d_mem_err_t !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got=%b exp=0", d_mem_err_t); end
        n_checks++; if (mem_req_t !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req got=%b exp=0", mem_req_t); end
        n_checks++; if (mem_we_t !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we got=%b exp=0", mem_we_t); end
        n_checks++; if (mem_addr_t !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_addr got=%h exp=0", mem_addr_t); end
        n_checks++; if (d_mem_rd_data_t !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rd_data got=%h exp=0", d_mem_rd_data_t); end
        #1 rst_t = 1'b0;
        exp_rd = 32'h0;
    endtask

    task automatic test_load_word;
        int busy, lb, nr;
        bit done, err, ok;
        wait_states = 0;
        mem[32'h10] = 8'h78; mem[32'h11] = 8'h56; mem[32'h12] = 8'h34; mem[32'h13] = 8'h12;
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, busy, done, err, lb, nr);
        exp_rd = 32'h12345678;
        n_checks++; if (!done || err) begin n_fail++; $display("[TB] FAIL lw_done done=%b err=%b exp done=1 err=0", done, err); end
        n_checks++; if (busy != 5) begin n_fail++; $display("[TB] FAIL lw_latency busy=%0d exp=5", busy); end
        n_checks++; if (d_mem_rd_data_t !== exp_rd) begin n_fail++; $display("[TB] FAIL lw_data got=%h exp=%h", d_mem_rd_data_t, exp_rd); end
        ok = (xlog.size() - lb == 4);
        for (int k = 0; ok && k < 4; k++)
            if (xlog[lb+k].we !== 1'b0 || xlog[lb+k].addr !== 32'h10 + 32'(k)) ok = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL lw_bus_addrs transfers=%0d exp 4 reads at 0x10..0x13", xlog.size() - lb); end
    endtask

    task automatic test_extend;
        int busy, lb, nr;
        bit done, err;
        wait_states = 0;
        mem[32'h13] = 8'h80;
        do_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, busy, done, err, lb, nr);
        exp_rd = 32'hFFFFFF80;
        n_checks++; if (d_mem_rd_data_t !== exp_rd || !done) begin n_fail++; $display("[TB] FAIL lb_sign got=%h exp=%h", d_mem_rd_data_t, exp_rd); end
        do_access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, busy, done, err, lb, nr);
        exp_rd = 32'h00000080;
        n_checks++; if (d_mem_rd_data_t !== exp_rd || !done) begin n_fail++; $display("[TB] FAIL lbu_zero got=%h exp=%h", d_mem_rd_data_t, exp_rd); end
        mem[32'h12] = 8'h01; mem[32'h13] = 8'hF0;
        do_access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, busy, done, err, lb, nr);
        exp_rd = 32'h0000F001;
        n_checks++; if (d_mem_rd_data_t !== exp_rd || !done) begin n_fail++; $display("[TB] FAIL lhu_zero got=%h exp=%h", d_mem_rd_data_t, exp_rd); end
    endtask

    task automatic test_store_half;
        int busy, lb, nr;
        bit done, err, ok;
        wait_states = 0;
        do_access(1'b0, 1'b1, 3'b001, 32'h22, 32'hABCD1234, busy, done, err, lb, nr);
        n_checks++; if (!done || err) begin n_fail++; $display("[TB] FAIL sh_done done=%b err=%b exp done=1 err=0", done, err); end
        ok = (xlog.size() - lb == 2);
        if (ok) ok = (xlog[lb] == xfer_t'{1'b1, 32'h22, 8'h34}) && (xlog[lb+1] == xfer_t'{1'b1, 32'h23, 8'h12});
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL sh_writes transfers=%0d exp 34@22,12@23", xlog.size() - lb); end
        n_checks++; if (d_mem_rd_data_t !== exp_rd) begin n_fail++; $display("[TB] FAIL sh_rd_data got=%h exp=%h", d_mem_rd_data_t, exp_rd); end
    endtask

    task automatic test_illegal;
        bit          t_rd[3];
        bit          t_wr[3];
        logic [2:0]  t_sz[3];
        logic [31:0] t_ad[3];
        int busy, lb, nr;
        bit done, err;
        t_rd = '{1'b1, 1'b0, 1'b1};
        t_wr = '{1'b0, 1'b1, 1'b1};
        t_sz = '{3'b001, 3'b010, 3'b010};
        t_ad = '{32'h21, 32'h06, 32'h10};
        for (int i = 0; i < 3; i++) begin
            do_access(t_rd[i], t_wr[i], t_sz[i], t_ad[i], 32'hDEADBEEF, busy, done, err, lb, nr);
            n_checks++; if (!done || !err || busy != 1) begin n_fail++; $display("[TB] FAIL illegal_%0d done=%b err=%b busy=%0d exp 1/1/1", i, done, err, busy); end
            n_checks++; if (nr != 0) begin n_fail++; $display("[TB] FAIL illegal_%0d_req req_cycles=%0d exp=0", i, nr); end
            n_checks++; if (d_mem_rd_data_t !== exp_rd) begin n_fail++; $display("[TB] FAIL illegal_%0d_rd_data got=%h exp=%h", i, d_mem_rd_data_t, exp_rd); end
        end
    endtask

    task automatic test_wait_states;
        int busy, lb, nr;
        bit done, err;
        wait_states = 3;
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, busy, done, err, lb, nr);
        n_checks++; if (!done || err || busy != 17) begin n_fail++; $display("[TB] FAIL sw_wait done=%b err=%b busy=%0d exp 1/0/17", done, err, busy); end
        n_checks++; if (rd_mem(32'h43) !== 8'h11 || rd_mem(32'h40) !== 8'h44) begin n_fail++; $display("[TB] FAIL sw_wait_mem got=%h..%h exp=11..44", rd_mem(32'h43), rd_mem(32'h40)); end
        wait_states = 0;
        never_ack   = 1'b1;
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, busy, done, err, lb, nr);
        never_ack   = 1'b0;
        n_checks++; if (!done || !err || busy != 5) begin n_fail++; $display("[TB] FAIL timeout done=%b err=%b busy=%0d exp 1/1/5", done, err, busy); end
        n_checks++; if (d_mem_rd_data_t !== exp_rd) begin n_fail++; $display("[TB] FAIL timeout_rd_data got=%h exp=%h", d_mem_rd_data_t, exp_rd); end
    endtask

    task automatic test_reset_mid;
        bit found, bad;
        wait_states = 0;
        found = 1'b0;
        @(negedge clk_t);
        d_mem_rd_en_t = 1'b1;
        d_mem_size_t  = 3'b010;
        d_mem_addr_t  = 32'h10;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk_t);
            #1;
            if (mem_req_t && mem_addr_t == 32'h12) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL rst_mid_reach_byte2 got=0 exp=1"); end
        #1 rst_t = 1'b1;
        d_mem_rd_en_t = 1'b0;
        #1;
        exp_rd = 32'h0;
        n_checks++; if (mem_req_t !== 1'b0 || d_mem_busy_t !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_req req=%b busy=%b exp 0/0", mem_req_t, d_mem_busy_t); end
        n_checks++; if (d_mem_rd_data_t !== 32'h0 || d_mem_done_t !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_outputs rd=%h done=%b exp 0/0", d_mem_rd_data_t, d_mem_done_t); end
        @(negedge clk_t);
        #2 rst_t = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_t);
            #1;
            if (d_mem_done_t || mem_req_t || d_mem_busy_t) bad = 1'b1;
        end
        n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL rst_mid_quiet activity=1 exp=0"); end
    endtask

    // Random mix of legal and illegal accesses issued back to back.
    task automatic test_random;
        logic [2:0]  sizes[8];
        logic [31:0] addr, data, exp_load;
        logic [2:0]  size;
        bit          rd, wr, ill, done, err, ok;
        int          busy, lb, nr, n, exp_busy, pick;
        sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int a = 32'h100; a < 32'h148; a++) mem[32'(a)] = 8'($urandom);
        for (int it = 0; it < 40; it++) begin
            pick = $urandom_range(0, 9);
            rd   = (pick < 5) || (pick == 9);
            wr   = (pick >= 5);
            size = sizes[($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)];
            addr = 32'h100 + 32'($urandom_range(0, 63));
            if (size == 3'b101) addr[0] = 1'b0;
            data = $urandom;
            wait_states = $urandom_range(0, 2);
            ill  = model_illegal(rd, wr, size, addr);
            n    = model_nbytes(size);
            exp_load = model_load(size, addr);
            exp_busy = ill ? 1 : 1 + n * (wait_states + 1);
            do_access(rd, wr, size, addr, data, busy, done, err, lb, nr);
            if (!ill && rd) exp_rd = exp_load;
            n_checks++; if (!done || err !== ill) begin n_fail++; $display("[TB] FAIL rand_%0d_err done=%b err=%b exp err=%b", it, done, err, ill); end
            n_checks++; if (busy != exp_busy) begin n_fail++; $display("[TB] FAIL rand_%0d_busy got=%0d exp=%0d", it, busy, exp_busy); end
            n_checks++; if (d_mem_rd_data_t !== exp_rd) begin n_fail++; $display("[TB] FAIL rand_%0d_rd_data got=%h exp=%h", it, d_mem_rd_data_t, exp_rd); end
            if (ill) ok = (nr == 0) && (xlog.size() == lb);
            else begin
                ok = (xlog.size() - lb == n);
                for (int k = 0; ok && k < n; k++)
                    if (xlog[lb+k] != xfer_t'{wr, addr + 32'(k), wr ? 8'(data >> (8 * k)) : 8'h00}) ok = 1'b0;
            end
            n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL rand_%0d_bus transfers=%0d exp=%0d", it, xlog.size() - lb, ill ? 0 : n); end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_extend();
        test_store_half();
        test_illegal();
        test_wait_states();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
